fp_mul_round: RTL and testbench

- Pipelined normalize-and-round stage that sits directly downstream of the combinational single-precision mantissa multiplier in the FP datapath.
- Consumes the raw 48-bit significand product, the raw exponent sum and the result sign.
- Produces a packed IEEE-754 single-precision result with round-to-nearest-even, plus status flags.
- No NaN/Inf support. Overflow saturates to max finite; underflow flushes to signed zero. Uses a valid/ready handshake so the multicycle controller can stall it.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_rne_round.sv | 41 ++++
 rtl/fp_mul_round.sv | 101 ++++++++++
 tb/tb_fp_mul_round.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 constants, field records and rounding helper for the FP datapath.
package fp_pkg;

   localparam int          FP_EXP_W      = 10;
   localparam int          FP32_BIAS     = 127;
   localparam logic [7:0]  FP32_EXP_MAX  = 8'hFE;
   localparam logic [22:0] FP32_FRAC_MAX = 23'h7FFFFF;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef struct packed {
      logic                       sign;
      logic                       zero;
      logic signed [FP_EXP_W-1:0] exp;
      logic [22:0]                frac;
      logic                       guard;
      logic                       sticky;
   } s1_rec_t;

   // Round-to-nearest-even increment decision.
   function automatic logic rne_incr(input logic lsb, input logic guard, input logic sticky);
      return guard & (sticky | lsb);
   endfunction

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even and pack of a normalized record into FP32,
// with saturate-on-overflow and flush-on-underflow.
module fp_rne_round
   import fp_pkg::*;
(
   input  s1_rec_t rec,
   output fp32_t   result,
   output logic    ovf,
   output logic    unf,
   output logic    inexact
);

   localparam logic signed [FP_EXP_W-1:0] EXP_OVF  = FP_EXP_W'(255);
   localparam logic signed [FP_EXP_W-1:0] EXP_ZERO = FP_EXP_W'(0);

   logic [23:0]                frac_sum;
   logic signed [FP_EXP_W-1:0] exp_r;

   // Increment, absorb a carry-out into the exponent, then classify by priority.
   always_comb begin
      frac_sum = {1'b0, rec.frac} + {23'd0, rne_incr(rec.frac[0], rec.guard, rec.sticky)};
      exp_r    = rec.exp + (frac_sum[23] ? FP_EXP_W'(1) : FP_EXP_W'(0));
      result   = '0;
      ovf      = 1'b0;
      unf      = 1'b0;
      inexact  = rec.guard | rec.sticky;
      if (rec.zero) begin
         result  = {rec.sign, 31'd0};
         inexact = 1'b0;
      end else if (exp_r >= EXP_OVF) begin
         result = {rec.sign, FP32_EXP_MAX, FP32_FRAC_MAX};
         ovf    = 1'b1;
      end else if (exp_r <= EXP_ZERO) begin
         result = {rec.sign, 31'd0};
         unf    = 1'b1;
      end else begin
         result = {rec.sign, exp_r[7:0], frac_sum[22:0]};
      end
   end

endmodule

// File: rtl/fp_mul_round.sv
// Two-stage normalize/round stage behind the FP32 mantissa multiplier, with a
// valid/ready handshake that lets the downstream controller stall it.
module fp_mul_round
   import fp_pkg::*;
#(
   parameter int EXP_W = FP_EXP_W,
   parameter int BIAS  = FP32_BIAS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [8:0]  in_exp_sum,
   input  logic [47:0] in_prod,
   input  logic        in_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_ovf,
   output logic        out_unf,
   output logic        out_inexact
);

   s1_rec_t            s1_rec;
   s1_rec_t            s1_next;
   logic               s1_valid;
   logic               s2_valid;
   logic               s2_en;
   logic [EXP_W-1:0]   exp_calc;
   fp32_t              rnd_result;
   logic               rnd_ovf;
   logic               rnd_unf;
   logic               rnd_inexact;
   fp32_t              s2_result;

   assign s2_en    = !s2_valid | out_ready;
   assign in_ready = !s1_valid | s2_en;

   // Normalize: a product in [2,4) shifts one place further and bumps the exponent.
   always_comb begin
      exp_calc       = EXP_W'(in_exp_sum) - EXP_W'(in_prod[47] ? BIAS - 1 : BIAS);
      s1_next        = '0;
      s1_next.sign   = in_sign;
      s1_next.zero   = in_zero;
      s1_next.exp    = FP_EXP_W'(exp_calc);
      if (in_prod[47]) begin
         s1_next.frac   = in_prod[46:24];
         s1_next.guard  = in_prod[23];
         s1_next.sticky = |in_prod[22:0];
      end else begin
         s1_next.frac   = in_prod[45:23];
         s1_next.guard  = in_prod[22];
         s1_next.sticky = |in_prod[21:0];
      end
   end

   // Stage 1 register: accepts whenever it is empty or stage 2 can take its contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_rec   <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_rec <= s1_next;
         end
      end
   end

   fp_rne_round u_round (
      .rec     (s1_rec),
      .result  (rnd_result),
      .ovf     (rnd_ovf),
      .unf     (rnd_unf),
      .inexact (rnd_inexact)
   );

   // Stage 2 register: outputs only change on a real load so stalls hold them steady.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid    <= 1'b0;
         s2_result   <= '0;
         out_ovf     <= 1'b0;
         out_unf     <= 1'b0;
         out_inexact <= 1'b0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result   <= rnd_result;
            out_ovf     <= rnd_ovf;
            out_unf     <= rnd_unf;
            out_inexact <= rnd_inexact;
         end
      end
   end

   assign out_valid  = s2_valid;
   assign out_result = s2_result;

endmodule

// File: tb/tb_fp_mul_round.sv
// Self-checking bench for fp_mul_round: directed corner cases plus randomized
// streaming against an arithmetic reference model.
module tb_fp_mul_round;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [8:0]  in_exp_sum = 9'd0;
   logic [47:0] in_prod = 48'd0;
   logic        in_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_ovf;
   logic        out_unf;
   logic        out_inexact;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        sign;
      logic [8:0]  es;
      logic [47:0] p;
      logic        zero;
   } op_t;

   typedef struct {
      op_t         op;
      logic [34:0] want;
      string       name;
   } dir_t;

   logic [34:0] exp_q[$];

   always #5 clk = ~clk;

   fp_mul_round dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sign     (in_sign),
      .in_exp_sum  (in_exp_sum),
      .in_prod     (in_prod),
      .in_zero     (in_zero),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_ovf     (out_ovf),
      .out_unf     (out_unf),
      .out_inexact (out_inexact)
   );

   // Reference: exact integer quotient/remainder rounding, returns {result, ovf, unf, inexact}.
   function automatic logic [34:0] model(input op_t op);
      longint unsigned p, mant, rem, half;
      int              sh, e;
      logic            inex;
      logic [22:0]     fr;
      if (op.zero) return {op.sign, 31'd0, 3'b000};
      p    = 64'(op.p);
      sh   = op.p[47] ? 24 : 23;
      mant = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      e    = int'(op.es) - 127 + (op.p[47] ? 1 : 0);
      inex = (rem != 64'd0);
      if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin
         mant = mant >> 1;
         e    = e + 1;
      end
      fr = mant[22:0];
      if (e >= 255) return {op.sign, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, inex};
      if (e <= 0) return {op.sign, 31'd0, 1'b0, 1'b1, inex};
      return {op.sign, e[7:0], fr, 1'b0, 1'b0, inex};
   endfunction

   function automatic op_t rand_op();
      op_t         op;
      logic [23:0] ma, mb;
      ma      = 24'($urandom()) | 24'h800000;
      mb      = 24'($urandom()) | 24'h800000;
      op.p    = 48'(ma) * 48'(mb);
      op.es   = 9'($urandom_range(0, 510));
      op.sign = 1'($urandom());
      op.zero = ($urandom_range(0, 15) == 0);
      return op;
   endfunction

   task automatic set_op(input op_t op);
      in_valid   = 1'b1;
      in_sign    = op.sign;
      in_exp_sum = op.es;
      in_prod    = op.p;
      in_zero    = op.zero;
   endtask

   task automatic set_idle();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #11;
      n_cmp++;
      if ({out_valid, out_result, out_ovf, out_unf, out_inexact} !== 36'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0",
                  {out_valid, out_result, out_ovf, out_unf, out_inexact});
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      dir_t t[7];
      t[0] = '{'{1'b0, 9'd254, 48'h900000000000, 1'b0}, {32'h40100000, 3'b000}, "1.5x1.5"};
      t[1] = '{'{1'b0, 9'd254, 48'h400000400000, 1'b0}, {32'h3F800000, 3'b001}, "tie_even"};
      t[2] = '{'{1'b0, 9'd254, 48'h400000C00000, 1'b0}, {32'h3F800002, 3'b001}, "tie_odd"};
      t[3] = '{'{1'b0, 9'd254, 48'h7FFFFFC00000, 1'b0}, {32'h40000000, 3'b001}, "carry_out"};
      t[4] = '{'{1'b1, 9'd400, 48'h400000000000, 1'b0}, {32'hFF7FFFFF, 3'b100}, "overflow"};
      t[5] = '{'{1'b0, 9'd100, 48'h400000000000, 1'b0}, {32'h00000000, 3'b010}, "underflow"};
      t[6] = '{'{1'b1, 9'd254, 48'h900000000000, 1'b1}, {32'h80000000, 3'b000}, "zero"};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         set_op(t[i].op);
         @(negedge clk);
         set_idle();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_early: out_valid got %b want 0", t[i].name, out_valid);
         end
         @(negedge clk);
         n_cmp++;
         if ({out_valid, out_result, out_ovf, out_unf, out_inexact} !== {1'b1, t[i].want}) begin
            n_bad++;
            $display("FAIL %s: got v=%b %h flags=%b%b%b want v=1 %h flags=%b", t[i].name,
                     out_valid, out_result, out_ovf, out_unf, out_inexact,
                     t[i].want[34:3], t[i].want[2:0]);
         end
      end
   endtask

   task automatic test_backpressure();
      op_t         ops[4];
      int          accepted = 0;
      int          drained = 0;
      logic [34:0] held = '0;
      logic [34:0] want;
      for (int i = 0; i < 4; i++) ops[i] = rand_op();
      exp_q.delete();
      for (int cyc = 0; cyc < 40 && drained < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 3);
         if (accepted < 4) set_op(ops[accepted]);
         else set_idle();
         #1;
         if (cyc == 2) begin
            n_cmp++;
            if ({in_ready, out_valid} !== 2'b01) begin
               n_bad++;
               $display("FAIL bp_full: in_ready/out_valid got %b%b want 01", in_ready, out_valid);
            end
            held = {out_result, out_ovf, out_unf, out_inexact};
         end
         if (cyc == 3) begin
            n_cmp++;
            if ({out_valid, out_result, out_ovf, out_unf, out_inexact} !== {1'b1, held}) begin
               n_bad++;
               $display("FAIL bp_hold: got %b %h want 1 %h", out_valid,
                        {out_result, out_ovf, out_unf, out_inexact}, held);
            end
         end
         if (out_valid && out_ready) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7FFFFFFFF;
            n_cmp++;
            if ({out_result, out_ovf, out_unf, out_inexact} !== want) begin
               n_bad++;
               $display("FAIL bp_order: got %h want %h",
                        {out_result, out_ovf, out_unf, out_inexact}, want);
            end
            drained++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(ops[accepted]));
            accepted++;
         end
      end
      @(negedge clk);
      set_idle();
      n_cmp++;
      if (drained != 4 || exp_q.size() != 0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_count: drained %0d left %0d out_valid %b want 4 0 0",
                  drained, exp_q.size(), out_valid);
      end
   endtask

   task automatic test_reset_mid();
      op_t op;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         set_op(rand_op());
      end
      @(negedge clk);
      set_idle();
      #1;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b10) begin
         n_bad++;
         $display("FAIL rm_full: out_valid/in_ready got %b%b want 10", out_valid, in_ready);
      end
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, out_result} !== 33'd0) begin
         n_bad++;
         $display("FAIL rm_async: got %b %h want 0 0", out_valid, out_result);
      end
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_stale: out_valid got %b want 0", out_valid);
         end
      end
      op = rand_op();
      set_op(op);
      @(negedge clk);
      set_idle();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rm_early: out_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_result, out_ovf, out_unf, out_inexact} !== {1'b1, model(op)}) begin
         n_bad++;
         $display("FAIL rm_after: got %b %h want 1 %h", out_valid,
                  {out_result, out_ovf, out_unf, out_inexact}, model(op));
      end
   endtask

   task automatic test_random();
      op_t         cur;
      logic        have = 1'b0;
      logic [34:0] want;
      exp_q.delete();
      for (int cyc = 0; cyc < 420; cyc++) begin
         @(negedge clk);
         if (!have && cyc < 400 && $urandom_range(0, 3) != 0) begin
            cur  = rand_op();
            have = 1'b1;
         end
         out_ready = (cyc >= 400) || ($urandom_range(0, 9) < 7);
         if (have) set_op(cur);
         else set_idle();
         #1;
         if (out_valid && out_ready) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7FFFFFFFF;
            n_cmp++;
            if ({out_result, out_ovf, out_unf, out_inexact} !== want) begin
               n_bad++;
               $display("FAIL rand_result: got %h want %h",
                        {out_result, out_ovf, out_unf, out_inexact}, want);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(cur));
            have = 1'b0;
         end
      end
      n_cmp++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rand_drain: left %0d out_valid %b want 0 0", exp_q.size(), out_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
